// File: rtl/lcd1602_readback_if.sv
// Bus bundle for lcd1602_readback: request/status handshake, read-back string
// and the HD44780 8-bit panel bus.
// Optional compare feature: define LCD_READBACK_CMP_EN to add the expected
// string input and the mismatch/mismatch_idx result outputs.
interface lcd1602_readback_if;
    logic         start;
    logic         busy;
    logic         done;
    logic         error;
    logic [255:0] string_out;
    logic [7:0]   LCD_DATA_I;
    logic [7:0]   LCD_DATA_O;
    logic         LCD_DATA_OE;
    logic         LCD_RW;
    logic         LCD_RS;
    logic         LCD_EN;
`ifdef LCD_READBACK_CMP_EN
    logic [255:0] expected;
    logic         mismatch;
    logic [4:0]   mismatch_idx;

    modport slave (
        input  start, LCD_DATA_I, expected,
        output busy, done, error, string_out,
        output LCD_DATA_O, LCD_DATA_OE, LCD_RW, LCD_RS, LCD_EN,
        output mismatch, mismatch_idx
    );
    modport master (
        output start, LCD_DATA_I, expected,
        input  busy, done, error, string_out,
        input  LCD_DATA_O, LCD_DATA_OE, LCD_RW, LCD_RS, LCD_EN,
        input  mismatch, mismatch_idx
    );
`else
    modport slave (
        input  start, LCD_DATA_I,
        output busy, done, error, string_out,
        output LCD_DATA_O, LCD_DATA_OE, LCD_RW, LCD_RS, LCD_EN
    );
    modport master (
        output start, LCD_DATA_I,
        input  busy, done, error, string_out,
        input  LCD_DATA_O, LCD_DATA_OE, LCD_RW, LCD_RS, LCD_EN
    );
`endif
endinterface

// File: rtl/lcd1602_readback.sv
// lcd1602_readback: reads all 32 DDRAM characters back from an HD44780-type
// panel, polling the busy flag before every bus operation.
// Optional feature macro: LCD_READBACK_CMP_EN (per-character compare against
// an expected string, first mismatch latched).
module lcd1602_readback #(
    parameter int SETUP_CYC    = 2,
    parameter int EN_HIGH_CYC  = 25,
    parameter int EN_LOW_CYC   = 25,
    parameter int BUSY_TIMEOUT = 1000
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    lcd1602_readback_if.slave    bus
);
    localparam int BUS_CYC = SETUP_CYC + EN_HIGH_CYC + EN_LOW_CYC;
    localparam int CW      = $clog2(BUS_CYC + 1);
    localparam int TW      = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [CW-1:0] CYC_EN_ON  = CW'(SETUP_CYC);
    localparam logic [CW-1:0] CYC_EN_OFF = CW'(SETUP_CYC + EN_HIGH_CYC);
    localparam logic [CW-1:0] CYC_SAMPLE = CW'(SETUP_CYC + EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] CYC_LAST   = CW'(BUS_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_POLL, S_SETADDR, S_READ} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [4:0]    idx_q;
    logic [TW-1:0] tmo_q;
    logic          bf_q;
    logic          addr_set_q;
    logic          done_q;
    logic          error_q;
    logic [255:0]  str_q;
    logic          en_q, rs_q, rw_q, oe_q;
    logic [7:0]    dout_q;
    logic          accept, cyc_end, finish, abort;
    logic          sample_now;

    assign sample_now = (cyc_q == CYC_SAMPLE);

    // Next-state: sequence POLL/SETADDR/READ bus cycles, each BUS_CYC clocks long
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        accept  = 1'b0;
        cyc_end = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;
        if (state_q == S_IDLE) begin
            // a start landing on the done clock is dropped
            if (bus.start && !done_q) begin
                accept  = 1'b1;
                state_d = S_POLL;
                cyc_d   = '0;
            end
        end else if (cyc_q != CYC_LAST) begin
            cyc_d = cyc_q + 1'b1;
        end else begin
            cyc_end = 1'b1;
            cyc_d   = '0;
            case (state_q)
                S_POLL: begin
                    if (bf_q) begin
                        if (tmo_q == TMO_LAST) begin
                            abort   = 1'b1;
                            finish  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if ((idx_q == 5'd0 || idx_q == 5'd16) && !addr_set_q) begin
                        state_d = S_SETADDR;
                    end else begin
                        state_d = S_READ;
                    end
                end
                S_SETADDR: state_d = S_POLL;
                S_READ: begin
                    if (idx_q == 5'd31) begin
                        finish  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_POLL;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and bus-cycle phase registers
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
        end
    end

    // Panel pins: RS/RW/OE/DATA_O only move at the start of a bus cycle, EN follows the phase
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            rs_q   <= 1'b0;
            rw_q   <= 1'b1;
            oe_q   <= 1'b0;
            dout_q <= 8'h00;
        end else begin
            en_q <= (state_d != S_IDLE) && (cyc_d >= CYC_EN_ON) && (cyc_d < CYC_EN_OFF);
            if (accept || cyc_end) begin
                case (state_d)
                    S_SETADDR: begin
                        rs_q   <= 1'b0;
                        rw_q   <= 1'b0;
                        oe_q   <= 1'b1;
                        dout_q <= (idx_q == 5'd0) ? 8'h80 : 8'hC0;
                    end
                    S_READ: begin
                        rs_q   <= 1'b1;
                        rw_q   <= 1'b1;
                        oe_q   <= 1'b0;
                        dout_q <= 8'h00;
                    end
                    default: begin
                        rs_q   <= 1'b0;
                        rw_q   <= 1'b1;
                        oe_q   <= 1'b0;
                        dout_q <= 8'h00;
                    end
                endcase
            end
        end
    end

    // Character index, busy-flag capture, timeout count and line-address bookkeeping
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            idx_q      <= '0;
            tmo_q      <= '0;
            bf_q       <= 1'b0;
            addr_set_q <= 1'b0;
        end else if (accept) begin
            idx_q      <= '0;
            tmo_q      <= '0;
            bf_q       <= 1'b0;
            addr_set_q <= 1'b0;
        end else begin
            if (state_q == S_POLL && sample_now) begin
                bf_q <= bus.LCD_DATA_I[7];
            end
            if (cyc_end) begin
                case (state_q)
                    S_POLL:    tmo_q <= bf_q ? tmo_q + 1'b1 : '0;
                    S_SETADDR: addr_set_q <= 1'b1;
                    S_READ: begin
                        addr_set_q <= 1'b0;
                        if (idx_q != 5'd31) begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Results: done pulse, sticky error, character store on the last EN-high clock
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            str_q   <= '0;
        end else begin
            done_q <= finish;
            if (accept) begin
                error_q <= 1'b0;
            end else if (abort) begin
                error_q <= 1'b1;
            end
            if (state_q == S_READ && sample_now) begin
                str_q[255 - 8*idx_q -: 8] <= bus.LCD_DATA_I;
            end
        end
    end

`ifdef LCD_READBACK_CMP_EN
    logic       mismatch_q;
    logic [4:0] mismatch_idx_q;

    // First differing character against the expected string
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            mismatch_q     <= 1'b0;
            mismatch_idx_q <= '0;
        end else if (accept) begin
            mismatch_q     <= 1'b0;
            mismatch_idx_q <= '0;
        end else if (state_q == S_READ && sample_now && !mismatch_q &&
                     bus.LCD_DATA_I != bus.expected[255 - 8*idx_q -: 8]) begin
            mismatch_q     <= 1'b1;
            mismatch_idx_q <= idx_q;
        end
    end

    assign bus.mismatch     = mismatch_q;
    assign bus.mismatch_idx = mismatch_idx_q;
`endif

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.string_out  = str_q;
    assign bus.LCD_EN      = en_q;
    assign bus.LCD_RS      = rs_q;
    assign bus.LCD_RW      = rw_q;
    assign bus.LCD_DATA_OE = oe_q;
    assign bus.LCD_DATA_O  = dout_q;
endmodule
